// File: rtl/icon_blit_ctrl_pkg.sv
// icon_pkg: shared constants and state encoding for the icon blitter.
//   ICON_W/ICON_H    icon size in pixels
//   WORDS_PER_ICON   48-bit ROM words per icon (two pixels per word)
//   SCREEN_W/H       framebuffer geometry
//   KEY_COLOR        transparent colour
//   blit_state_t     controller states
//   icon_base()      first ROM word address of an icon
package icon_pkg;

  localparam int ICON_W         = 80;
  localparam int ICON_H         = 80;
  localparam int WORDS_PER_ICON = ICON_W * ICON_H / 2;
  localparam int SCREEN_W       = 640;
  localparam int SCREEN_H       = 480;
  localparam logic [23:0] KEY_COLOR = 24'hFF00FF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    EMIT0,
    EMIT1,
    DONE
  } blit_state_t;

  // 15*3200+3199 = 51199, so 16 bits always suffice.
  function automatic logic [15:0] icon_base(input logic [3:0] num);
    return 16'(num) * 16'(WORDS_PER_ICON);
  endfunction

endpackage

// File: rtl/icon_blit_ctrl_if.sv
// icon_blit_ctrl_if: command, icon ROM and framebuffer write signals of the
// blitter.
//   slave  : controller view (consumes commands/ROM data/ready, drives the rest)
//   master : environment view (command source, ROM, framebuffer port)
interface icon_blit_ctrl_if;

  logic        iCmd_valid;
  logic        oCmd_ready;
  logic [3:0]  iCmd_number;
  logic [9:0]  iCmd_x;
  logic [8:0]  iCmd_y;
  logic        iAbort;
  logic [15:0] oRom_address;
  logic [47:0] iRom_data;
  logic        oFb_we;
  logic [18:0] oFb_addr;
  logic [23:0] oFb_data;
  logic        iFb_ready;
  logic        oBusy;
  logic        oDone;

  modport slave (
    input  iCmd_valid, iCmd_number, iCmd_x, iCmd_y, iAbort, iRom_data, iFb_ready,
    output oCmd_ready, oRom_address, oFb_we, oFb_addr, oFb_data, oBusy, oDone
  );

  modport master (
    output iCmd_valid, iCmd_number, iCmd_x, iCmd_y, iAbort, iRom_data, iFb_ready,
    input  oCmd_ready, oRom_address, oFb_we, oFb_addr, oFb_data, oBusy, oDone
  );

endinterface

// File: rtl/icon_blit_ctrl_fb_addr.sv
// icon_fb_addr: maps an icon-relative pixel to the screen.
//   x, y       icon top-left on screen
//   col, row   pixel position inside the icon
//   on_screen  pixel lies inside SCREEN_W x SCREEN_H
//   lin_addr   y*SCREEN_W + x linear framebuffer address (valid when on_screen)
module icon_fb_addr
  import icon_pkg::*;
(
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic [6:0]  col,
  input  logic [6:0]  row,
  output logic        on_screen,
  output logic [18:0] lin_addr
);

  logic [10:0] sx;
  logic [9:0]  sy;

  assign sx = {1'b0, x} + {4'b0, col};
  assign sy = {1'b0, y} + {3'b0, row};

  assign on_screen = (sx < 11'(SCREEN_W)) && (sy < 10'(SCREEN_H));
  // Only meaningful on screen, where 479*640+639 fits in 19 bits.
  assign lin_addr  = 19'(sy) * 19'(SCREEN_W) + 19'(sx);

endmodule

// File: rtl/icon_blit_ctrl.sv
// icon_blit_ctrl: draws one 80x80 icon from the icon ROM into the framebuffer.
//   iCLK, iRST_N  clock, synchronous active-low reset
//   bus           command handshake, abort, ROM address/data, framebuffer
//                 write port (we/addr/data/ready), busy and done status
//   KEY_EN        1 = KEY_COLOR pixels are skipped, 0 = they are written
// Per ROM word: FETCH (address out) -> LATCH (data back) -> EMIT0 (even
// pixel) -> EMIT1 (odd pixel). Write strobes are registered, so each EMIT
// state's write is prepared on the transition into it.
module icon_blit_ctrl
  import icon_pkg::*;
#(
  parameter bit KEY_EN = 1'b1
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  icon_blit_ctrl_if.slave  bus
);

  blit_state_t state;
  logic [15:0] base;
  logic [9:0]  x_q;
  logic [8:0]  y_q;
  logic [11:0] word_idx;
  logic [6:0]  col, row;
  // Even pixel goes straight to oFb_data in LATCH; only the odd half waits.
  logic [23:0] hold_odd;

  logic [6:0]  col_inc, row_inc, pc, pr;
  logic [23:0] pix;
  logic        on_scr, vis, adv, last;
  logic [18:0] lin;

  always_comb begin
    col_inc = col + 7'd1;
    row_inc = row;
    if (col == 7'(ICON_W - 1)) begin
      col_inc = '0;
      row_inc = row + 7'd1;
    end
  end

  // Look-ahead pixel: in LATCH the even pixel at (col,row) is next; in EMIT0
  // the odd pixel one step further on.
  assign pc   = (state == LATCH) ? col : col_inc;
  assign pr   = (state == LATCH) ? row : row_inc;
  assign pix  = (state == LATCH) ? bus.iRom_data[47:24] : hold_odd;

  icon_fb_addr u_fb_addr (
    .x         (x_q),
    .y         (y_q),
    .col       (pc),
    .row       (pr),
    .on_screen (on_scr),
    .lin_addr  (lin)
  );

  assign vis  = on_scr && !(KEY_EN && (pix == KEY_COLOR));
  assign adv  = !bus.oFb_we || bus.iFb_ready;
  assign last = (word_idx == 12'(WORDS_PER_ICON - 1));

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state            <= IDLE;
      base             <= '0;
      x_q              <= '0;
      y_q              <= '0;
      word_idx         <= '0;
      col              <= '0;
      row              <= '0;
      hold_odd         <= '0;
      bus.oCmd_ready   <= 1'b1;
      bus.oRom_address <= '0;
      bus.oFb_we       <= 1'b0;
      bus.oFb_addr     <= '0;
      bus.oFb_data     <= '0;
      bus.oBusy        <= 1'b0;
      bus.oDone        <= 1'b0;
    end else if (bus.iAbort && state != IDLE) begin
      // Pending write is dropped; no done pulse.
      state          <= IDLE;
      bus.oFb_we     <= 1'b0;
      bus.oDone      <= 1'b0;
      bus.oCmd_ready <= 1'b1;
      bus.oBusy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.iCmd_valid && bus.oCmd_ready) begin
            base             <= icon_base(bus.iCmd_number);
            bus.oRom_address <= icon_base(bus.iCmd_number);
            x_q              <= bus.iCmd_x;
            y_q              <= bus.iCmd_y;
            word_idx         <= '0;
            col              <= '0;
            row              <= '0;
            bus.oCmd_ready   <= 1'b0;
            bus.oBusy        <= 1'b1;
            state            <= FETCH;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          hold_odd     <= bus.iRom_data[23:0];
          bus.oFb_we   <= vis;
          bus.oFb_addr <= lin;
          bus.oFb_data <= pix;
          state        <= EMIT0;
        end
        EMIT0: begin
          if (adv) begin
            col          <= col_inc;
            row          <= row_inc;
            bus.oFb_we   <= vis;
            bus.oFb_addr <= lin;
            bus.oFb_data <= pix;
            state        <= EMIT1;
          end
        end
        EMIT1: begin
          if (adv) begin
            col        <= col_inc;
            row        <= row_inc;
            bus.oFb_we <= 1'b0;
            if (last) begin
              bus.oDone <= 1'b1;
              state     <= DONE;
            end else begin
              word_idx         <= word_idx + 12'd1;
              bus.oRom_address <= base + {4'b0, word_idx} + 16'd1;
              state            <= FETCH;
            end
          end
        end
        DONE: begin
          bus.oDone      <= 1'b0;
          bus.oCmd_ready <= 1'b1;
          bus.oBusy      <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icon_blit_ctrl.sv
// Bench for icon_blit_ctrl: two instances (KEY_EN=1 and KEY_EN=0) share the
// command/abort stimulus; the KEY_EN=1 instance is scored pixel by pixel
// against a queue built from the icon/screen rules, the other by write count.
module tb_icon_blit_ctrl;
  import icon_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  icon_blit_ctrl_if bus();
  icon_blit_ctrl_if bus_nk();

  icon_blit_ctrl #(.KEY_EN(1'b1)) dut (
    .iCLK(clk), .iRST_N(rst_n), .bus(bus.slave)
  );
  icon_blit_ctrl #(.KEY_EN(1'b0)) dut_nk (
    .iCLK(clk), .iRST_N(rst_n), .bus(bus_nk.slave)
  );

  assign bus_nk.iCmd_valid  = bus.iCmd_valid;
  assign bus_nk.iCmd_number = bus.iCmd_number;
  assign bus_nk.iCmd_x      = bus.iCmd_x;
  assign bus_nk.iCmd_y      = bus.iCmd_y;
  assign bus_nk.iAbort      = bus.iAbort;
  assign bus_nk.iFb_ready   = 1'b1;

  int checks = 0, errors = 0;
  int cyc = 0, mode = 0, rdy_mode = 0, stall_left = 0, abort_at = 0;
  int nwr = 0, nwr_nk = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0;
  bit abort_fired = 0;
  logic [42:0] exp_q[$];
  logic [47:0] rom_q, rom_nk_q;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ROM contents as a pure function of address: 0 = address pattern,
  // 1 = hashed with occasional key pixels, 2 = every even pixel is key.
  function automatic logic [47:0] rom_word(input logic [15:0] a, input int md);
    logic [31:0] h;
    logic [23:0] ev, od;
    h = ({16'h0, a} * 32'h9E3779B1) ^ 32'h1234_5678;
    case (md)
      1: begin
        ev = h[31:8];
        od = h[23:0] ^ 24'h5A5A5A;
        if (h[3:0] == 4'h0) ev = KEY_COLOR;
        if (h[7:4] == 4'h0) od = KEY_COLOR;
      end
      2: begin ev = KEY_COLOR; od = {8'h30, a}; end
      default: begin ev = {8'h10, a}; od = {8'h20, a}; end
    endcase
    return {ev, od};
  endfunction

  always @(posedge clk) begin
    rom_q    <= rom_word(bus.oRom_address, mode);
    rom_nk_q <= rom_word(bus_nk.oRom_address, mode);
  end
  assign bus.iRom_data    = rom_q;
  assign bus_nk.iRom_data = rom_nk_q;

  always @(posedge clk) cyc++;

  // Ready / abort driver, just after each active edge.
  always begin
    @(posedge clk);
    #1;
    if (abort_at > 0 && nwr == abort_at) begin
      bus.iAbort    = 1'b1;
      bus.iFb_ready = 1'b0;
      abort_at      = 0;
      abort_fired   = 1;
    end else begin
      bus.iAbort = 1'b0;
      if (stall_left > 0 && bus.oFb_we) begin
        bus.iFb_ready = 1'b0;
        stall_left--;
      end else
        bus.iFb_ready = (rdy_mode == 0) ? 1'b1 : 1'(($urandom % 4) != 0);
    end
  end

  // Scoreboard: every cycle a write is requested it must match the next
  // expected pixel; it is consumed only when accepted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.oFb_we) begin
        if (exp_q.size() == 0) chk("fb_extra_wr_qsize", 64'(exp_q.size()), 64'd1);
        else chk("fb_px", 64'({bus.oFb_addr, bus.oFb_data}), 64'(exp_q[0]));
        if (bus.iFb_ready) begin
          nwr++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
      if (bus_nk.oFb_we && bus_nk.iFb_ready) nwr_nk++;
      if (bus.oDone) begin done_cnt++; done_cyc = cyc; end
    end
  end

  // Expected writes straight from geometry: pixel (col,row) is word
  // (row*80+col)/2, even column = high half.
  task automatic build_exp(input int num, input int x, input int y, input int md,
                           output int n_key, output int n_nokey);
    logic [47:0] w;
    logic [23:0] p;
    int sx, sy;
    exp_q.delete();
    n_key = 0; n_nokey = 0;
    for (int r = 0; r < ICON_H; r++)
      for (int c = 0; c < ICON_W; c++) begin
        w  = rom_word(16'(num * WORDS_PER_ICON + (r * ICON_W + c) / 2), md);
        p  = (c % 2 == 0) ? w[47:24] : w[23:0];
        sx = x + c; sy = y + r;
        if (sx < SCREEN_W && sy < SCREEN_H) begin
          n_nokey++;
          if (p != KEY_COLOR) begin
            exp_q.push_back({19'(sy * SCREEN_W + sx), p});
            n_key++;
          end
        end
      end
  endtask

  task automatic issue(input int num, input int x, input int y);
    bit ok = 0;
    @(posedge clk); #1;
    bus.iCmd_valid = 1'b1; bus.iCmd_number = 4'(num);
    bus.iCmd_x = 10'(x); bus.iCmd_y = 9'(y);
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (bus.oCmd_ready) begin ok = 1; acc_cyc = cyc + 1; end
    end
    @(posedge clk); #1;
    bus.iCmd_valid = 1'b0;
    chk("cmd_accepted", 64'(ok), 64'd1);
    @(negedge clk);
    chk("first_rom_addr", 64'(bus.oRom_address), 64'(num * WORDS_PER_ICON));
    chk("busy_after_accept", 64'(bus.oBusy), 64'd1);
  endtask

  task automatic run_blit(input int num, input int x, input int y, input int md,
                          input int rm, input bit tmg, input int exp_n, input int exp_nk);
    int n_k, n_nk, t;
    build_exp(num, x, y, md, n_k, n_nk);
    mode = md; rdy_mode = rm;
    nwr = 0; nwr_nk = 0; done_cnt = 0;
    issue(num, x, y);
    t = 0;
    while (done_cnt == 0 && t < 40000) begin @(negedge clk); t++; end
    chk("done_seen", 64'(done_cnt), 64'd1);
    if (tmg) chk("done_latency", 64'(done_cyc - acc_cyc), 64'd12800);
    repeat (3) @(negedge clk);
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("wr_count_model", 64'(nwr), 64'(n_k));
    if (exp_n >= 0) chk("wr_count", 64'(nwr), 64'(exp_n));
    chk("exp_left", 64'(exp_q.size()), 64'd0);
    chk("nk_wr_count_model", 64'(nwr_nk), 64'(n_nk));
    if (exp_nk >= 0) chk("nk_wr_count", 64'(nwr_nk), 64'(exp_nk));
    chk("idle_ready", 64'(bus.oCmd_ready), 64'd1);
    chk("idle_busy", 64'(bus.oBusy), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_k, n_nk, t;
    rst_n = 1'b0;
    bus.iCmd_valid = 1'b1; bus.iCmd_number = 4'd3; bus.iCmd_x = '0; bus.iCmd_y = '0;
    bus.iAbort = 1'b0; bus.iFb_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 64'(bus.oCmd_ready), 64'd1);
      chk("rst_busy", 64'(bus.oBusy), 64'd0);
      chk("rst_we", 64'(bus.oFb_we), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; bus.iCmd_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("post_rst_ready", 64'(bus.oCmd_ready), 64'd1);
    chk("post_rst_busy", 64'(bus.oBusy), 64'd0);
    chk("post_rst_done", 64'(bus.oDone), 64'd0);
    chk("post_rst_rom", 64'(bus.oRom_address), 64'd0);
    chk("post_rst_out", 64'({bus.oFb_we, bus.oFb_addr, bus.oFb_data}), 64'd0);

    // Full unclipped blit, address pattern, no backpressure.
    run_blit(2, 0, 0, 0, 0, 1'b1, 6400, 6400);
    // Bottom-right clipping: 40x30 visible.
    run_blit(0, 600, 450, 0, 0, 1'b1, 1200, 1200);
    // Backpressure: 5-cycle stall on the first (even) write, then random ready.
    stall_left = 5;
    run_blit(9, 100, 200, 0, 1, 1'b0, 6400, 6400);
    // Key colour on every even pixel.
    run_blit(4, 320, 100, 2, 0, 1'b1, 3200, 6400);

    // Abort after the 100th accepted write, with a command attempted while busy.
    build_exp(5, 10, 20, 1, n_k, n_nk);
    mode = 1; rdy_mode = 0; nwr = 0; done_cnt = 0; abort_fired = 0;
    abort_at = 100;
    issue(5, 10, 20);
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    bus.iCmd_valid = 1'b1; bus.iCmd_number = 4'd7; bus.iCmd_x = '0; bus.iCmd_y = '0;
    repeat (5) begin
      @(negedge clk);
      chk("busy_cmd_ready", 64'(bus.oCmd_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.iCmd_valid = 1'b0;
    t = 0;
    while (!abort_fired && t < 2000) begin @(negedge clk); t++; end
    chk("abort_fired", 64'(abort_fired), 64'd1);
    @(negedge clk); @(negedge clk);
    chk("abort_ready", 64'(bus.oCmd_ready), 64'd1);
    chk("abort_busy", 64'(bus.oBusy), 64'd0);
    chk("abort_we", 64'(bus.oFb_we), 64'd0);
    repeat (50) @(negedge clk);
    chk("abort_wr_count", 64'(nwr), 64'd100);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    exp_q.delete();

    // Fresh command after abort: random icon and position, hashed ROM.
    run_blit(int'($urandom % 16), int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
             1, 0, 1'b1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icon_blit_ctrl.md
Name: icon_blit_ctrl

Overview:
Sequencer that draws one 80x80 icon from the shared icon ROM into the 640x480 24-bit framebuffer at a commanded screen position. It accepts a blit command, walks all 3200 ROM words of the selected icon (two pixels per 48-bit word), clips off-screen pixels, skips key-colour pixels, and issues framebuffer writes under backpressure. It sits between the game/menu logic (command source) and the icon ROM plus framebuffer write port.

Parameters:
ICON_W, 80, icon width in pixels
ICON_H, 80, icon height in pixels
WORDS_PER_ICON, 3200, 48-bit ROM words per icon (ICON_W*ICON_H/2)
SCREEN_W, 640, framebuffer width
SCREEN_H, 480, framebuffer height
KEY_COLOR, 24'hFF00FF, transparent colour, never written
KEY_EN, 1, 1 = skip KEY_COLOR pixels, 0 = write them

Ports:
iCLK  in  1  system clock
iRST_N  in  1  synchronous active-low reset
iCmd_valid  in  1  command present
oCmd_ready  out  1  high only in IDLE; command accepted on valid&&ready
iCmd_number  in  4  icon index 0..15
iCmd_x  in  10  screen x of icon top-left
iCmd_y  in  9  screen y of icon top-left
iAbort  in  1  cancel current blit
oRom_address  out  16  icon ROM word address
iRom_data  in  48  ROM word; [47:24] even pixel, [23:0] odd pixel; RGB 8:8:8
oFb_we  out  1  framebuffer write request
oFb_addr  out  19  linear address y*SCREEN_W+x
oFb_data  out  24  RGB pixel
iFb_ready  in  1  write accepted on oFb_we&&iFb_ready
oBusy  out  1  high in any state except IDLE
oDone  out  1  one-cycle pulse on normal completion

Behaviour:
- Single clock iCLK; reset synchronous, active-low on iRST_N. Reset: state IDLE, oCmd_ready=1, oFb_we=0, oDone=0, oBusy=0, oRom_address=0, oFb_addr=0, oFb_data=0, all counters 0.
- Command latched on accept (number, x, y); word_idx, col, row cleared; next state FETCH.
- ROM is synchronous, 1-cycle latency: data for address driven in cycle t is valid in cycle t+1.
- States: IDLE -> FETCH (drive oRom_address=number*3200+word_idx; 16-bit result, max 51199) -> LATCH (capture iRom_data into 48-bit hold register) -> EMIT0 (even pixel) -> EMIT1 (odd pixel) -> FETCH, or DONE after last word -> IDLE.
- EMIT state: screen sx=x+col (11 bits), sy=y+row (10 bits). Pixel visible iff sx<SCREEN_W, sy<SCREEN_H, and !(KEY_EN && pixel==KEY_COLOR).
  - Visible: oFb_we=1, oFb_addr=sy*640+sx, oFb_data=pixel; addr/data held stable until iFb_ready; advance on the accept cycle.
  - Not visible: oFb_we=0, advance after one cycle.
- Pixel advance: col++, at col==ICON_W-1 wrap to 0 and row++. word_idx++ on leaving EMIT1.
- Last word is word_idx==WORDS_PER_ICON-1. Leaving EMIT1 on it -> DONE: oDone=1 for exactly that cycle, oCmd_ready=0; then IDLE.
- Throughput with iFb_ready=1: 4 cycles/word. A full unclipped blit runs 12800 cycles from accept to DONE.
- iAbort in any non-IDLE state: next cycle IDLE, oFb_we=0 (a pending write is dropped), no oDone. iAbort in IDLE is ignored.
- iCmd_valid while busy is not accepted. Command fields are ignored after latching.
- Reset mid-blit behaves as abort and also clears all outputs to reset values.

Decomposition:
- Package icon_pkg: ICON_W, ICON_H, WORDS_PER_ICON, SCREEN_W, SCREEN_H, KEY_COLOR, and the state encoding (IDLE, FETCH, LATCH, EMIT0, EMIT1, DONE).
- One combinational sub-module, icon_fb_addr: inputs x, y, col, row; outputs visible-on-screen flag and 19-bit linear address. Key-colour test stays in the controller.

Test Plan:
- Reset held 3 cycles with iCmd_valid=1 -> oCmd_ready=1, oBusy=0, oFb_we=0, no command accepted; after release, all outputs match reset values.
- Icon 2 at (0,0), iFb_ready=1, ROM returns an address-derived pattern -> first oRom_address=6400; first writes go to addr 0 and addr 1 with data [47:24] then [23:0]; 6400 writes total; oDone pulses 12800 cycles after accept.
- Icon 0 at (600,450) -> 40x30=1200 writes only; first write addr 288600; no write with sx>=640 or sy>=480; oDone still pulses once.
- Backpressure: iFb_ready=0 for 5 cycles during a visible EMIT0 -> oFb_we, oFb_addr and oFb_data stay stable; no pixel lost or duplicated; total write count unchanged.
- KEY_EN=1, every even pixel = FF00FF -> exactly 3200 writes, all to odd columns. With KEY_EN=0 -> 6400 writes.
- iAbort after the 100th accepted write -> next cycle IDLE, oCmd_ready=1, no oDone, no further writes. A command issued while busy is not accepted; a new command after the abort runs a full, correct blit.
